// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM symbol mapper.
// Holds the bin classification enum, the pilot-sign LFSR constants and the
// helpers that place the active band around the DC bin.
package ofdm_pkg;

    typedef enum logic [1:0] {
        BIN_NULL  = 2'd0,
        BIN_PILOT = 2'd1,
        BIN_DATA  = 2'd2
    } bin_class_e;

    // Pilot-sign PRBS: Fibonacci LFSR x^11 + x^9 + 1
    localparam int unsigned LFSR_W      = 11;
    localparam int unsigned LFSR_TAP_HI = 10;   // x^11 term
    localparam int unsigned LFSR_TAP_LO = 8;    // x^9 term

    // DC bin
    function automatic int unsigned bin_mid(input int unsigned ofdm_size);
        return ofdm_size / 2;
    endfunction

    // Lowest active bin
    function automatic int unsigned bin_left(input int unsigned ofdm_size,
                                             input int unsigned num_carrier);
        return (ofdm_size / 2) - (num_carrier / 2);
    endfunction

    // Highest active bin
    function automatic int unsigned bin_right(input int unsigned ofdm_size,
                                              input int unsigned num_carrier);
        return (ofdm_size / 2) + (num_carrier / 2);
    endfunction

endpackage

// File: rtl/ofdm_pilot_prbs.sv
// Pilot sign generator: 11-bit Fibonacci LFSR, sign taken from bit 0.
// Ports:
//   clk, res_n  clock, asynchronous active-low reset (loads SEED)
//   reload      load SEED on the next edge (wins over advance)
//   advance     step the LFSR once on the next edge
//   sign        current pilot sign (1 = negative pilot)
module ofdm_pilot_prbs
    import ofdm_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 11'h7FF
) (
    input  logic clk,
    input  logic res_n,
    input  logic reload,
    input  logic advance,
    output logic sign
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next LFSR state
    always_comb begin
        lfsr_d = lfsr_q;
        if (reload) begin
            lfsr_d = SEED;
        end else if (advance) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
        end
    end

    // LFSR register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign sign = lfsr_q[0];

endmodule

// File: rtl/ofdm_symbol_mapper.sv
// OFDM symbol mapper: walks the IFFT bins of each symbol in order and emits
// null bins, BPSK pilots (PRBS sign) or QAM data from the input stream.
// Ports:
//   clk, res_n            clock, asynchronous active-low reset
//   en                    global enable, 0 freezes all state
//   preamble              1 = next symbol is all pilots (sampled at bin 0)
//   qam_valid/qam_ready   QAM input handshake (qam_ready is combinational)
//   qam_i, qam_q          signed QAM sample
//   out_valid/out_ready   bin output handshake towards the IFFT
//   out_i, out_q          signed bin value
//   out_index             bin number
//   out_sop, out_eop      first / last bin of the symbol
module ofdm_symbol_mapper
    import ofdm_pkg::*;
#(
    parameter int unsigned       OFDM_SIZE     = 1024,
    parameter int unsigned       NUM_CARRIER   = 824,
    parameter int unsigned       DW            = 16,
    parameter int unsigned       PILOT_SPACING = 12,
    parameter logic [DW-1:0]     PILOT_AMP     = {1'b0, {(DW-1){1'b1}}},
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 11'h7FF
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic                         en,
    input  logic                         preamble,
    input  logic                         qam_valid,
    output logic                         qam_ready,
    input  logic signed [DW-1:0]         qam_i,
    input  logic signed [DW-1:0]         qam_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DW-1:0]         out_i,
    output logic signed [DW-1:0]         out_q,
    output logic [$clog2(OFDM_SIZE)-1:0] out_index,
    output logic                         out_sop,
    output logic                         out_eop
);

    localparam int unsigned IDXW = $clog2(OFDM_SIZE);
    localparam int unsigned SPW  = $clog2(PILOT_SPACING);

    localparam logic [IDXW-1:0] MID_IDX   = IDXW'(bin_mid(OFDM_SIZE));
    localparam logic [IDXW-1:0] LEFT_IDX  = IDXW'(bin_left(OFDM_SIZE, NUM_CARRIER));
    localparam logic [IDXW-1:0] RIGHT_IDX = IDXW'(bin_right(OFDM_SIZE, NUM_CARRIER));
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(OFDM_SIZE - 1);
    localparam logic [SPW-1:0]  SPC_LAST  = SPW'(PILOT_SPACING - 1);
    localparam logic [DW-1:0]   PILOT_NEG = ~PILOT_AMP + DW'(1);

    // Bin walk state
    logic [IDXW-1:0] bin_cnt, bin_nxt;
    logic [SPW-1:0]  spc_cnt, spc_nxt;
    logic            pre_lat, pre_nxt;

    // Output register next values
    logic            valid_nxt;
    logic [DW-1:0]   i_nxt, q_nxt;
    logic [IDXW-1:0] index_nxt;
    logic            sop_nxt, eop_nxt;

    logic       is_active;
    bin_class_e bin_class;
    logic       slot_free;
    logic       fire;
    logic       pilot_sign;

    // Classify the bin about to be emitted; bin 0 is always null, so the
    // latched preamble flag is valid for every bin that can be active.
    always_comb begin
        is_active = (bin_cnt >= LEFT_IDX) && (bin_cnt <= RIGHT_IDX) && (bin_cnt != MID_IDX);
        bin_class = BIN_NULL;
        if (is_active) begin
            if (pre_lat || (spc_cnt == '0)) begin
                bin_class = BIN_PILOT;
            end else begin
                bin_class = BIN_DATA;
            end
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign qam_ready = en && slot_free && (bin_class == BIN_DATA);
    assign fire      = en && slot_free && ((bin_class != BIN_DATA) || qam_valid);

    ofdm_pilot_prbs #(
        .SEED (LFSR_SEED)
    ) u_prbs (
        .clk     (clk),
        .res_n   (res_n),
        .reload  (fire && (bin_cnt == '0)),
        .advance (fire && (bin_class == BIN_PILOT)),
        .sign    (pilot_sign)
    );

    // Next state: emit one bin per fire, otherwise hold or drain the slot
    always_comb begin
        bin_nxt   = bin_cnt;
        spc_nxt   = spc_cnt;
        pre_nxt   = pre_lat;
        valid_nxt = out_valid;
        i_nxt     = out_i;
        q_nxt     = out_q;
        index_nxt = out_index;
        sop_nxt   = out_sop;
        eop_nxt   = out_eop;

        if (fire) begin
            bin_nxt = IDXW'(bin_cnt + 1'b1);
            if (bin_cnt == '0) begin
                pre_nxt = preamble;
            end
            // Spacing counter restarts each symbol so ordinal 0 lands on LEFT_IDX
            if (bin_cnt == LAST_IDX) begin
                spc_nxt = '0;
            end else if (is_active) begin
                spc_nxt = (spc_cnt == SPC_LAST) ? '0 : SPW'(spc_cnt + 1'b1);
            end

            valid_nxt = 1'b1;
            index_nxt = bin_cnt;
            sop_nxt   = (bin_cnt == '0);
            eop_nxt   = (bin_cnt == LAST_IDX);
            unique case (bin_class)
                BIN_PILOT: begin
                    i_nxt = pilot_sign ? PILOT_NEG : PILOT_AMP;
                    q_nxt = '0;
                end
                BIN_DATA: begin
                    i_nxt = qam_i;
                    q_nxt = qam_q;
                end
                default: begin
                    i_nxt = '0;
                    q_nxt = '0;
                end
            endcase
        end else if (en && out_ready) begin
            valid_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            bin_cnt   <= '0;
            spc_cnt   <= '0;
            pre_lat   <= 1'b0;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_index <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            bin_cnt   <= bin_nxt;
            spc_cnt   <= spc_nxt;
            pre_lat   <= pre_nxt;
            out_valid <= valid_nxt;
            out_i     <= i_nxt;
            out_q     <= q_nxt;
            out_index <= index_nxt;
            out_sop   <= sop_nxt;
            out_eop   <= eop_nxt;
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_mapper.sv
// Directed self-checking bench for ofdm_symbol_mapper (16-bin configuration).
module tb_ofdm_symbol_mapper;

    logic        clk = 1'b0;
    logic        res_n;
    logic        en;
    logic        preamble;
    logic        qam_valid;
    logic        qam_ready;
    logic [15:0] qam_i;
    logic [15:0] qam_q;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic [3:0]  out_index;
    logic        out_sop;
    logic        out_eop;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;   // QAM source sample number

    // Hand-derived bin maps: active 4-7,9-12; pilots at ordinals 0,3,6
    logic [15:0] active_map = 16'h1EF0;
    logic [15:0] pilot_map  = 16'h0890;
    logic [15:0] data_map   = 16'h1660;
    logic [15:0] neg_map    = 16'h0010;   // only the first pilot after seed 7FF is negative

    ofdm_symbol_mapper #(
        .OFDM_SIZE     (16),
        .NUM_CARRIER   (8),
        .DW            (16),
        .PILOT_SPACING (3),
        .PILOT_AMP     (16'h7FFF)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .en        (en),
        .preamble  (preamble),
        .qam_valid (qam_valid),
        .qam_ready (qam_ready),
        .qam_i     (qam_i),
        .qam_q     (qam_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_index (out_index),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected bin value: dk is the data ordinal of this bin within the stream
    function automatic void exp_bin(input int b, input bit pre, input int dk,
                                    output logic [15:0] ei, output logic [15:0] eq);
        if (!active_map[b]) begin
            ei = 16'h0000; eq = 16'h0000;
        end else if (pre || pilot_map[b]) begin
            ei = neg_map[b] ? 16'h8001 : 16'h7FFF; eq = 16'h0000;
        end else begin
            ei = 16'h1000 + 16'(dk); eq = 16'hF000 - 16'(dk);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src();
        qam_i = 16'h1000 + 16'(k);
        qam_q = 16'hF000 - 16'(k);
    endtask

    task automatic apply_reset();
        res_n = 1'b0; en = 1'b1; preamble = 1'b0; qam_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        drive_src();
        repeat (2) tick();
        res_n = 1'b1;
    endtask

    task automatic test_reset();
        res_n = 1'b0; en = 1'b1; preamble = 1'b0; qam_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        drive_src();
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if ({out_i, out_q} !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got i=%h q=%h expected 0", out_i, out_q);
        end
        n_checks++;
        if ({out_index, out_sop, out_eop} !== 6'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got idx=%0d sop=%b eop=%b expected 0/0/0", out_index, out_sop, out_eop);
        end
        n_checks++;
        if (qam_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_qam_ready: got %b expected 0", qam_ready);
        end
    endtask

    task automatic test_data_symbol();
        int got = 0; int ek = 0; int cyc = 0;
        logic [15:0] ei, eq;
        apply_reset();
        qam_valid = 1'b1;
        while (got < 16 && cyc < 100) begin
            drive_src();
            #1;
            if (out_valid && out_ready) begin
                exp_bin(got, 1'b0, ek, ei, eq);
                n_checks++;
                if ({out_index, out_sop, out_eop} !== {4'(got), got == 0, got == 15}) begin
                    n_fail++; $display("FAIL data_ctrl bin %0d: got idx=%0d sop=%b eop=%b", got, out_index, out_sop, out_eop);
                end
                n_checks++;
                if ({out_i, out_q} !== {ei, eq}) begin
                    n_fail++; $display("FAIL data_value bin %0d: got i=%h q=%h expected i=%h q=%h", got, out_i, out_q, ei, eq);
                end
                if (data_map[got]) ek++;
                got++;
            end
            if (qam_valid && qam_ready) k++;
            tick(); cyc++;
        end
        n_checks++;
        if (got != 16 || k != 5) begin
            n_fail++; $display("FAIL data_count: got %0d bins %0d qam consumed expected 16 and 5", got, k);
        end
    endtask

    task automatic test_preamble();
        int got = 0; int cyc = 0; int rdy_seen = 0;
        logic [15:0] ei, eq;
        apply_reset();
        preamble  = 1'b1;
        qam_valid = 1'b1;
        while (got < 16 && cyc < 100) begin
            drive_src();
            #1;
            if (qam_ready) rdy_seen++;
            if (out_valid && out_ready) begin
                exp_bin(got, 1'b1, 0, ei, eq);
                n_checks++;
                if ({out_index, out_i, out_q} !== {4'(got), ei, eq}) begin
                    n_fail++; $display("FAIL preamble_bin %0d: got idx=%0d i=%h q=%h expected i=%h q=%h", got, out_index, out_i, out_q, ei, eq);
                end
                got++;
            end
            if (qam_valid && qam_ready) k++;
            tick(); cyc++;
        end
        n_checks++;
        if (got != 16 || rdy_seen != 0 || k != 0) begin
            n_fail++; $display("FAIL preamble_no_qam: got bins=%0d ready_cycles=%0d consumed=%0d expected 16/0/0", got, rdy_seen, k);
        end
        preamble = 1'b0;
    endtask

    task automatic test_qam_stall();
        int got = 0; int ek = 0; int cyc = 0; int stall_left = 0; int gap = 0; int rdy_stall = 0;
        bit stall_done = 1'b0;
        logic [15:0] ei, eq;
        apply_reset();
        while (got < 16 && cyc < 100) begin
            if (!stall_done && out_valid && out_index == 4'd5) begin
                stall_left = 3; stall_done = 1'b1;
            end
            qam_valid = (stall_left == 0);
            drive_src();
            #1;
            if (stall_left > 0 && qam_ready) rdy_stall++;
            if (got == 6 && !out_valid) gap++;
            if (out_valid && out_ready) begin
                exp_bin(got, 1'b0, ek, ei, eq);
                n_checks++;
                if ({out_index, out_i, out_q} !== {4'(got), ei, eq}) begin
                    n_fail++; $display("FAIL stall_bin %0d: got idx=%0d i=%h q=%h expected i=%h q=%h", got, out_index, out_i, out_q, ei, eq);
                end
                if (data_map[got]) ek++;
                got++;
            end
            if (qam_valid && qam_ready) k++;
            if (stall_left > 0) stall_left--;
            tick(); cyc++;
        end
        n_checks++;
        if (got != 16 || gap != 3 || rdy_stall != 3 || k != 5) begin
            n_fail++; $display("FAIL stall_timing: got bins=%0d gap=%0d ready_in_stall=%0d consumed=%0d expected 16/3/3/5", got, gap, rdy_stall, k);
        end
    endtask

    task automatic test_out_backpressure();
        int got = 0; int ek = 0; int cyc = 0; int hold = 0;
        bit hold_done = 1'b0;
        logic [15:0] ei, eq, hi, hq;
        apply_reset();
        qam_valid = 1'b1;
        hi = '0; hq = '0;
        while (got < 16 && cyc < 100) begin
            if (!hold_done && out_valid && out_index == 4'd9) begin
                hold = 4; hold_done = 1'b1;
                exp_bin(9, 1'b0, ek, hi, hq);
            end
            out_ready = (hold == 0);
            drive_src();
            #1;
            if (hold > 0) begin
                n_checks++;
                if (!(out_valid === 1'b1 && out_index === 4'd9 && out_i === hi && out_q === hq && qam_ready === 1'b0)) begin
                    n_fail++; $display("FAIL backpressure_hold: got valid=%b idx=%0d i=%h q=%h ready=%b expected 1/9/%h/%h/0", out_valid, out_index, out_i, out_q, qam_ready, hi, hq);
                end
            end
            if (out_valid && out_ready) begin
                exp_bin(got, 1'b0, ek, ei, eq);
                n_checks++;
                if ({out_index, out_i, out_q} !== {4'(got), ei, eq}) begin
                    n_fail++; $display("FAIL backpressure_bin %0d: got idx=%0d i=%h q=%h expected i=%h q=%h", got, out_index, out_i, out_q, ei, eq);
                end
                if (data_map[got]) ek++;
                got++;
            end
            if (qam_valid && qam_ready) k++;
            if (hold > 0) hold--;
            tick(); cyc++;
        end
        n_checks++;
        if (got != 16 || k != 5 || !hold_done) begin
            n_fail++; $display("FAIL backpressure_count: got bins=%0d consumed=%0d held=%b expected 16/5/1", got, k, hold_done);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_enable();
        int got = 0; int ek = 0; int cyc = 0; int off = 0;
        bit off_done = 1'b0;
        logic [15:0] ei, eq;
        apply_reset();
        qam_valid = 1'b1;
        while (got < 16 && cyc < 100) begin
            if (!off_done && out_valid && out_index == 4'd7) begin
                off = 3; off_done = 1'b1;
            end
            en = (off == 0);
            drive_src();
            #1;
            if (off > 0) begin
                n_checks++;
                if (!(out_valid === 1'b1 && out_index === 4'd7 && out_i === 16'h7FFF && qam_ready === 1'b0)) begin
                    n_fail++; $display("FAIL enable_freeze: got valid=%b idx=%0d i=%h ready=%b expected 1/7/7fff/0", out_valid, out_index, out_i, qam_ready);
                end
            end
            if (en && out_valid && out_ready) begin
                exp_bin(got, 1'b0, ek, ei, eq);
                n_checks++;
                if ({out_index, out_i, out_q} !== {4'(got), ei, eq}) begin
                    n_fail++; $display("FAIL enable_bin %0d: got idx=%0d i=%h q=%h expected i=%h q=%h", got, out_index, out_i, out_q, ei, eq);
                end
                if (data_map[got]) ek++;
                got++;
            end
            if (en && qam_valid && qam_ready) k++;
            if (off > 0) off--;
            tick(); cyc++;
        end
        n_checks++;
        if (got != 16 || k != 5) begin
            n_fail++; $display("FAIL enable_count: got bins=%0d consumed=%0d expected 16/5", got, k);
        end
        en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int got = 0; int ek = 0; int cyc = 0; int gaps = 0;
        logic [15:0] ei, eq;
        apply_reset();
        qam_valid = 1'b1;
        while (got < 32 && cyc < 200) begin
            // Mid-symbol preamble pulse must not affect either symbol
            preamble = (got >= 6 && got <= 10);
            drive_src();
            #1;
            if (got > 0 && !out_valid) gaps++;
            if (out_valid && out_ready) begin
                exp_bin(got % 16, 1'b0, ek, ei, eq);
                n_checks++;
                if ({out_index, out_sop, out_eop} !== {4'(got % 16), (got % 16) == 0, (got % 16) == 15}) begin
                    n_fail++; $display("FAIL b2b_ctrl n=%0d: got idx=%0d sop=%b eop=%b", got, out_index, out_sop, out_eop);
                end
                n_checks++;
                if ({out_i, out_q} !== {ei, eq}) begin
                    n_fail++; $display("FAIL b2b_value n=%0d: got i=%h q=%h expected i=%h q=%h", got, out_i, out_q, ei, eq);
                end
                if (data_map[got % 16]) ek++;
                got++;
            end
            if (qam_valid && qam_ready) k++;
            tick(); cyc++;
        end
        n_checks++;
        if (got != 32 || gaps != 0 || k != 10) begin
            n_fail++; $display("FAIL b2b_count: got bins=%0d gaps=%0d consumed=%0d expected 32/0/10", got, gaps, k);
        end
        preamble = 1'b0;
    endtask

    task automatic test_reset_mid();
        int got = 0; int ek = 0; int cyc = 0;
        bit hit = 1'b0;
        logic [15:0] ei, eq;
        apply_reset();
        qam_valid = 1'b1;
        while (!hit && cyc < 60) begin
            drive_src();
            #1;
            if (out_valid && out_index == 4'd10) hit = 1'b1;
            else begin
                if (qam_valid && qam_ready) k++;
                tick();
            end
            cyc++;
        end
        n_checks++;
        if (!hit) begin
            n_fail++; $display("FAIL reset_mid_reach: index 10 not seen within %0d cycles", cyc);
        end
        res_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_sop, out_eop, out_index, out_i, out_q} !== 39'h0) begin
            n_fail++; $display("FAIL reset_mid_clear: got valid=%b idx=%0d i=%h q=%h sop=%b eop=%b expected all 0", out_valid, out_index, out_i, out_q, out_sop, out_eop);
        end
        tick(); tick();
        res_n = 1'b1;
        k = 0;
        cyc = 0;
        while (got < 16 && cyc < 100) begin
            drive_src();
            #1;
            if (out_valid && out_ready) begin
                exp_bin(got, 1'b0, ek, ei, eq);
                n_checks++;
                if ({out_index, out_sop, out_i, out_q} !== {4'(got), got == 0, ei, eq}) begin
                    n_fail++; $display("FAIL reset_mid_bin %0d: got idx=%0d sop=%b i=%h q=%h expected i=%h q=%h", got, out_index, out_sop, out_i, out_q, ei, eq);
                end
                if (data_map[got]) ek++;
                got++;
            end
            if (qam_valid && qam_ready) k++;
            tick(); cyc++;
        end
        n_checks++;
        if (got != 16) begin
            n_fail++; $display("FAIL reset_mid_count: got bins=%0d expected 16", got);
        end
    endtask

    initial begin
        test_reset();
        test_data_symbol();
        test_preamble();
        test_qam_stall();
        test_out_backpressure();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_symbol_mapper.md
OFDM_SYMBOL_MAPPER -- requirements
Module: ofdm_symbol_mapper

Interface
REQ-001 Parameter: OFDM_SIZE, default 1024, FFT length in bins; power of two, 16..4096.
REQ-002 Parameter: NUM_CARRIER, default 824, active carriers excluding DC; even, below OFDM_SIZE-2.
REQ-003 Parameter: DW, default 16, signed I/Q sample width.
REQ-004 Parameter: PILOT_SPACING, default 12, pilot period counted in active carriers; 2..64.
REQ-005 Parameter: PILOT_AMP, default 2^(DW-1)-1, pilot magnitude.
REQ-006 Parameter: LFSR_SEED, default 11'h7FF, pilot-sign PRBS seed.
REQ-007 Ports (name direction width meaning):
  clk  in  1  single clock, rising edge.
  res_n  in  1  reset, asynchronous assert, active-low.
  en  in  1  global enable; 0 freezes all state.
  preamble  in  1  1 = preamble symbol (all active bins pilots); sampled at symbol start.
  qam_valid  in  1  QAM sample offered.
  qam_ready  out  1  mapper consumes QAM sample this cycle.
  qam_i, qam_q  in  DW  signed QAM sample.
  out_valid  out  1  output sample valid.
  out_ready  in  1  downstream (IFFT) accepts sample.
  out_i, out_q  out  DW  signed bin value.
  out_index  out  log2(OFDM_SIZE)  bin number of out_i/out_q.
  out_sop, out_eop  out  1  first / last bin of symbol.

Function
REQ-008 Bins: mid = OFDM_SIZE/2, left = mid-NUM_CARRIER/2, right = mid+NUM_CARRIER/2; active = left..right except mid; all others null.
REQ-009 Active ordinal counts active bins from 0 at left; ordinal mod PILOT_SPACING == 0 marks a pilot bin, via a spacing counter, not a divider.
REQ-010 Null bin: out_i = out_q = 0, no QAM consumed.
REQ-011 Pilot bin: out_q = 0; out_i = -PILOT_AMP when sign bit is 1, +PILOT_AMP otherwise; no QAM consumed.
REQ-012 Data bin (preamble = 0): out_i/out_q = qam_i/qam_q of the consumed sample.
REQ-013 Preamble symbol: every active bin is a pilot bin; no QAM consumed for the whole symbol.
REQ-014 Sign: 11-bit Fibonacci LFSR x^11+x^9+1, sign = bit 0, advances once per emitted pilot, reloaded with LFSR_SEED at each out_sop.
REQ-015 Output register slot is free when out_valid = 0 or out_ready = 1; bin counter advances only when en = 1, the slot is free, and the current bin's data is available.
REQ-016 Data bin with qam_valid = 0: stall, no bubble, no zero fill; bin counter holds.
REQ-017 qam_ready = en & slot-free & current bin is data bin; combinational, independent of qam_valid.
REQ-018 Latency: one cycle from QAM handshake to out_valid.
REQ-019 out_valid held with out_i/out_q/out_index/out_sop/out_eop stable until out_ready = 1.
REQ-020 out_sop with out_index 0; out_eop with out_index OFDM_SIZE-1; counter wraps to 0; no gap between symbols.
REQ-021 preamble change mid-symbol takes effect only at the next index 0.
REQ-022 en = 0: no state change, qam_ready = 0, pending out_valid held.

Reset
REQ-023 res_n = 0 asynchronously clears out_valid, out_i, out_q, out_index, out_sop, out_eop, bin and spacing counters; LFSR = LFSR_SEED; preamble latch = 0.
REQ-024 Reset mid-symbol discards the partial symbol; first emitted bin after release is index 0 with out_sop.

Structure
REQ-025 Shared package ofdm_pkg holds bin-class enum (NULL, PILOT, DATA), LFSR polynomial/width constants, and helper function for left/right/mid.
REQ-026 One sub-module ofdm_pilot_prbs (LFSR with advance and reload inputs); remaining logic is flat.

Verification
REQ-027 Bench parameters: OFDM_SIZE=16, NUM_CARRIER=8, PILOT_SPACING=3, DW=16, PILOT_AMP=32767.
REQ-028 Data symbol, qam_valid = 1, out_ready = 1 -> pilots at bins 4,7,11; data at 5,6,9,10,12 (5 consumed); bins 0-3,8,13-15 = 0; bin 4 out_i = -32767.
REQ-029 Preamble = 1 -> bins 4,5,6,7,9,10,11,12 all pilots, out_q = 0, qam_ready never 1, signs follow LFSR from 11'h7FF.
REQ-030 qam_valid low 3 cycles at bin 6 -> output stalls at index 5, no zero inserted, bin 6 carries next QAM sample.
REQ-031 out_ready low 4 cycles at index 9 -> outputs stable, qam_ready = 0, resume with no loss or duplication.
REQ-032 Two back-to-back symbols -> out_eop at 15 then out_sop at 0 next accepted cycle; identical pilot signs in both.
REQ-033 res_n pulsed low at index 10 -> outputs cleared immediately; restart at index 0 with out_sop, LFSR reseeded.
